// File: rtl/regfile_scan.sv
// regfile_scan: parametrised register file for the multicycle RISC datapath.
// Two combinational read ports and one general write port. A dedicated PC
// write port is aliased to register NREGS-1. A valid/ready dump channel
// walks every register for a debug or display consumer.
// Optional feature macro: REGFILE_BYPASS_EN. When it is defined, both read
// ports forward same-cycle write data. dump_data is never forwarded.
module regfile_scan #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pc_wr_en,
  input  logic [WIDTH-1:0] pc_wr_data,
  input  logic             dump_req,
  input  logic             dump_ready,
  output logic             dump_valid,
  output logic [AW-1:0]    dump_idx,
  output logic [WIDTH-1:0] dump_data,
  output logic             dump_last,
  output logic             busy
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    DUMP = 1'b1
  } dump_state_e;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];

  dump_state_e      state_q, state_d;
  logic [AW-1:0]    dump_idx_q, dump_idx_d;
  logic             dump_valid_q;
  logic             busy_q;

  // Next register contents. The general write is applied last, so it
  // overrides a PC write to the same register.
  always_comb begin
    // NOTE: combinational logic uses blocking '='. Each statement sees the
    // result of the previous one, and that ordering gives wr_en priority.
    regs_d = regs_q;
    if (pc_wr_en) regs_d[NREGS-1] = pc_wr_data;
    if (wr_en)    regs_d[wr_addr] = wr_data;
  end

  // Storage update. Reset clears every register.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is cleared on reset, because software expects
    // every register to read as zero after reset. Sequential state uses
    // non-blocking '<='.
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read data for one port, with optional same-cycle forwarding.
  function automatic logic [WIDTH-1:0] read_port(
    input logic [AW-1:0]    addr,
    input logic             w_en,
    input logic [AW-1:0]    w_addr,
    input logic [WIDTH-1:0] w_data,
    input logic             p_en,
    input logic [WIDTH-1:0] p_data,
    input logic [WIDTH-1:0] stored
  );
`ifdef REGFILE_BYPASS_EN
    if (w_en && (w_addr == addr))     return w_data;
    else if (p_en && (addr == LAST_IDX)) return p_data;
    else                              return stored;
`else
    // Without forwarding, the pre-edge stored value is returned.
    logic unused;
    unused = w_en ^ p_en ^ (^w_addr) ^ (^w_data) ^ (^p_data) ^ (^addr);
    return stored;
`endif
  endfunction

  // Asynchronous read ports.
  always_comb begin
    rd_data_a = read_port(rd_addr_a, wr_en, wr_addr, wr_data,
                          pc_wr_en, pc_wr_data, regs_q[rd_addr_a]);
    rd_data_b = read_port(rd_addr_b, wr_en, wr_addr, wr_data,
                          pc_wr_en, pc_wr_data, regs_q[rd_addr_b]);
  end

  // Dump sequencer next state. The index advances only on a handshake,
  // and it returns to 0 only through IDLE.
  always_comb begin
    state_d    = state_q;
    dump_idx_d = dump_idx_q;
    unique case (state_q)
      IDLE: begin
        dump_idx_d = '0;
        if (dump_req) state_d = DUMP;
      end
      DUMP: begin
        if (dump_ready) begin
          if (dump_idx_q == LAST_IDX) begin
            state_d    = IDLE;
            dump_idx_d = '0;
          end else begin
            dump_idx_d = dump_idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        dump_idx_d = '0;
      end
    endcase
  end

  // Dump sequencer state and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      dump_idx_q   <= '0;
      dump_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dump_idx_q   <= dump_idx_d;
      dump_valid_q <= (state_d == DUMP);
      busy_q       <= (state_d == DUMP);
    end
  end

  // dump_data shows the live register contents, not a snapshot.
  assign dump_valid = dump_valid_q;
  assign busy       = busy_q;
  assign dump_idx   = dump_idx_q;
  assign dump_data  = regs_q[dump_idx_q];
  assign dump_last  = dump_valid_q && (dump_idx_q == LAST_IDX);

endmodule
